// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha block sequencer: FSM states,
// quarter-round operand schedule and the "expand 32-byte k" constants.
package chacha_pkg;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        OUT
    } state_e;

    // Rows 0-3 are the column round, rows 4-7 the diagonal round; entries are (a,b,c,d).
    localparam logic [3:0] QR_IDX [8][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15},
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    localparam logic [31:0] SIGMA [4] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
    };

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_core_qr.sv
// Combinational ChaCha quarter-round: one full (a,b,c,d) update per evaluation.
module qr
    import chacha_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [31:0] a1, b1, c1, d1;
    logic [31:0] a2, b2, c2, d2;

    assign a1 = a_i + b_i;
    assign d1 = rotl32(d_i ^ a1, 16);
    assign c1 = c_i + d1;
    assign b1 = rotl32(b_i ^ c1, 12);
    assign a2 = a1 + b1;
    assign d2 = rotl32(d1 ^ a2, 8);
    assign c2 = c1 + d2;
    assign b2 = rotl32(b1 ^ c2, 7);

    assign a_o = a2;
    assign b_o = b2;
    assign c_o = c2;
    assign d_o = d2;

endmodule

// File: rtl/chacha_core.sv
// ChaCha block function sequencer: serial 16-word load, one quarter-round per
// cycle through a single qr instance, then serial 16-word output.
module chacha_core
    import chacha_pkg::*;
#(
    parameter int unsigned ROUNDS       = 20,
    parameter bit          FEED_FORWARD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int unsigned STEPS = 4 * ROUNDS;
    localparam int unsigned SW    = $clog2(STEPS);

    if ((ROUNDS % 2) != 0 || ROUNDS < 2) begin : g_bad_rounds
        $error("chacha_core: ROUNDS must be even and >= 2");
    end

    state_e        state_q, state_d;
    logic [31:0]   st_q   [16];
    logic [31:0]   st_d   [16];
    logic [31:0]   orig_q [16];
    logic [31:0]   orig_d [16];
    logic [3:0]    k_q, k_d;
    logic [SW-1:0] s_q, s_d;

    logic [2:0]    sel;
    logic [3:0]    ia, ib, ic, id;
    logic [31:0]   qa, qb, qc, qd;
    logic          in_fire, out_fire, last_step;

    assign sel       = s_q[2:0];
    assign ia        = QR_IDX[sel][0];
    assign ib        = QR_IDX[sel][1];
    assign ic        = QR_IDX[sel][2];
    assign id        = QR_IDX[sel][3];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_step = (s_q == SW'(STEPS - 1));

    qr u_qr (
        .a_i (st_q[ia]),
        .b_i (st_q[ib]),
        .c_i (st_q[ic]),
        .d_i (st_q[id]),
        .a_o (qa),
        .b_o (qb),
        .c_o (qc),
        .d_o (qd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (in_fire && k_q == 4'd15) state_d = RUN;
            RUN:     if (last_step) state_d = OUT;
            OUT:     if (out_fire && k_q == 4'd15) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == LOAD) && !rst;
        out_valid = (state_q == OUT);
        busy      = (state_q != LOAD);
        out_data  = '0;
        if (state_q == OUT) begin
            out_data = FEED_FORWARD ? st_q[k_q] + orig_q[k_q] : st_q[k_q];
        end
    end

    // k wraps 15->0 on its own, so it is already 0 on entry to RUN and back to LOAD.
    always_comb begin
        st_d   = st_q;
        orig_d = orig_q;
        k_d    = k_q;
        s_d    = s_q;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    st_d[k_q]   = in_data;
                    orig_d[k_q] = in_data;
                    k_d         = k_q + 4'd1;
                end
            end
            RUN: begin
                st_d[ia] = qa;
                st_d[ib] = qb;
                st_d[ic] = qc;
                st_d[id] = qd;
                s_d      = last_step ? '0 : s_q + SW'(1);
            end
            OUT: begin
                if (out_fire) k_d = k_q + 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
            s_q <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                st_q[i]   <= '0;
                orig_q[i] <= '0;
            end
        end else begin
            k_q    <= k_d;
            s_q    <= s_d;
            st_q   <= st_d;
            orig_q <= orig_d;
        end
    end

endmodule

// File: tb/tb_chacha_core.sv
// Self-checking bench for chacha_core: transaction-level ChaCha model plus
// per-cycle comparison of a FEED_FORWARD=1 and a FEED_FORWARD=0 instance.
module tb_chacha_core;
    import chacha_pkg::*;

    localparam int R = 20;
    typedef logic [31:0] blk_t [16];
    typedef enum {M_FILL, M_CRUNCH, M_DRAIN} mphase_e;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_data;
    logic        in_ready1, out_valid1, busy1;
    logic [31:0] out_data1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chacha_core #(.ROUNDS(R), .FEED_FORWARD(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    chacha_core #(.ROUNDS(R), .FEED_FORWARD(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference block function: R/2 double rounds of column then diagonal quarter-rounds.
    function automatic void ref_block(input blk_t in_w, output blk_t ff, output blk_t raw);
        blk_t x;
        int   q[4];
        x = in_w;
        for (int r = 0; r < R / 2; r++)
            for (int half = 0; half < 2; half++)
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) q[j] = 4 * j + ((i + half * j) % 4);
                    x[q[0]] += x[q[1]]; x[q[3]] = rotl(x[q[3]] ^ x[q[0]], 16);
                    x[q[2]] += x[q[3]]; x[q[1]] = rotl(x[q[1]] ^ x[q[2]], 12);
                    x[q[0]] += x[q[1]]; x[q[3]] = rotl(x[q[3]] ^ x[q[0]], 8);
                    x[q[2]] += x[q[3]]; x[q[1]] = rotl(x[q[1]] ^ x[q[2]], 7);
                end
        raw = x;
        for (int i = 0; i < 16; i++) ff[i] = x[i] + in_w[i];
    endfunction

    // Transaction model state and observation logs
    mphase_e     ph = M_FILL;
    logic [31:0] in_buf[$];
    logic [31:0] e_ff[$];
    logic [31:0] e_raw[$];
    logic [31:0] log0[$];
    logic [31:0] log1[$];
    int          acc0_cyc[$];
    int          hs15_cyc[$];
    int          cyc = 0;
    int          run_left = 0;
    int          last_acc_cyc = 0;
    int          first_valid_cyc = 0;
    logic        ov_prev = 1'b0;
    blk_t        m_in, m_f, m_w;

    always @(negedge clk) begin
        logic        drain;
        logic [31:0] x_ff, x_raw;
        #1;
        cyc++;
        drain = (ph == M_DRAIN);
        x_ff  = '0;
        x_raw = '0;
        if (drain && e_ff.size() > 0) begin
            x_ff  = e_ff[0];
            x_raw = e_raw[0];
        end
        chk("in_ready", in_ready, (ph == M_FILL) && !rst);
        chk("busy", busy, ph != M_FILL);
        chk("out_valid", out_valid, drain);
        chk("out_data", out_data, x_ff);
        chk("raw_out_valid", out_valid1, drain);
        chk("raw_out_data", out_data1, x_raw);

        if (out_valid && out_ready) log0.push_back(out_data);
        if (out_valid1 && out_ready) log1.push_back(out_data1);
        if (out_valid && !ov_prev) first_valid_cyc = cyc;
        ov_prev = out_valid;

        if (rst) begin
            ph = M_FILL;
            in_buf.delete();
            e_ff.delete();
            e_raw.delete();
        end else begin
            case (ph)
                M_FILL: if (in_valid) begin
                    if (in_buf.size() == 0) acc0_cyc.push_back(cyc);
                    in_buf.push_back(in_data);
                    if (in_buf.size() == 16) begin
                        for (int i = 0; i < 16; i++) m_in[i] = in_buf[i];
                        ref_block(m_in, m_f, m_w);
                        for (int i = 0; i < 16; i++) begin
                            e_ff.push_back(m_f[i]);
                            e_raw.push_back(m_w[i]);
                        end
                        in_buf.delete();
                        last_acc_cyc = cyc;
                        run_left = 4 * R;
                        ph = M_CRUNCH;
                    end
                end
                M_CRUNCH: begin
                    run_left--;
                    if (run_left == 0) ph = M_DRAIN;
                end
                M_DRAIN: if (out_ready) begin
                    void'(e_ff.pop_front());
                    void'(e_raw.pop_front());
                    if (e_ff.size() == 0) begin
                        hs15_cyc.push_back(cyc);
                        ph = M_FILL;
                    end
                end
                default: ph = M_FILL;
            endcase
        end
    end

    task automatic load_block(input blk_t w, input bit gaps);
        int k = 0;
        int guard = 0;
        while (k < 16 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = w[k];
                if (in_ready) k++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (k < 16) begin
            failures++;
            $display("FAIL load_block: accepted %0d words expected 16", k);
        end
    endtask

    task automatic wait_outputs(input int n);
        int guard = 0;
        while (log0.size() < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (log0.size() < n) begin
            failures++;
            $display("FAIL wait_outputs: got %0d words expected %0d", log0.size(), n);
        end
    endtask

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog: time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t rfc, rfc2, zero_b, r_ff, r_raw, r2_ff, r2_raw;
        int   guard;

        rfc = '{SIGMA[0], SIGMA[1], SIGMA[2], SIGMA[3],
                32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        rfc2 = rfc;
        rfc2[12] = 32'h00000002;
        for (int i = 0; i < 16; i++) zero_b[i] = '0;

        ref_block(rfc, r_ff, r_raw);
        ref_block(rfc2, r2_ff, r2_raw);
        chk("model_w0", r_ff[0], 32'he4e7f110);
        chk("model_w1", r_ff[1], 32'h15593bd1);
        chk("model_w2", r_ff[2], 32'h1fdd0f50);
        chk("model_w3", r_ff[3], 32'hc47120a3);
        chk("model_w15", r_ff[15], 32'h4e3c50a2);
        chk("model_raw_w0", r_raw[0], 32'h837778ab);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 32'h0);

        // RFC vector, no stalls
        log0.delete(); log1.delete();
        load_block(rfc, 1'b0);
        wait_outputs(16);
        chk("rfc_w0", log0[0], 32'he4e7f110);
        chk("rfc_w1", log0[1], 32'h15593bd1);
        chk("rfc_w2", log0[2], 32'h1fdd0f50);
        chk("rfc_w3", log0[3], 32'hc47120a3);
        chk("rfc_w15", log0[15], 32'h4e3c50a2);
        chk("rfc_raw_w0", log1[0], 32'h837778ab);
        chk("rfc_latency", first_valid_cyc - last_acc_cyc, 4 * R + 1);

        // All-zero block
        log0.delete(); log1.delete();
        load_block(zero_b, 1'b0);
        wait_outputs(16);
        for (int i = 0; i < 16; i++) chk("zero_word", log0[i], 32'h0);

        // Input gaps and a 5-cycle output stall mid-stream
        log0.delete(); log1.delete();
        load_block(rfc, 1'b1);
        guard = 0;
        while (log0.size() < 6 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        wait_outputs(16);
        for (int i = 0; i < 16; i++) chk("stall_word", log0[i], r_ff[i]);

        // Reset at RUN step 37, then a clean reload
        load_block(rfc, 1'b0);
        repeat (37) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("midrun_reset_busy", busy, 1'b0);
        chk("midrun_reset_in_ready", in_ready, 1'b1);
        log0.delete(); log1.delete();
        load_block(rfc, 1'b0);
        wait_outputs(16);
        for (int i = 0; i < 16; i++) chk("post_reset_word", log0[i], r_ff[i]);
        chk("post_reset_w0", log0[0], 32'he4e7f110);

        // Back-to-back blocks, counter 1 then 2
        log0.delete(); log1.delete();
        acc0_cyc.delete(); hs15_cyc.delete();
        load_block(rfc, 1'b0);
        load_block(rfc2, 1'b0);
        wait_outputs(32);
        for (int i = 0; i < 16; i++) chk("b2b_blk1_word", log0[i], r_ff[i]);
        for (int i = 0; i < 16; i++) chk("b2b_blk2_word", log0[16 + i], r2_ff[i]);
        checks++;
        if (acc0_cyc.size() < 2 || hs15_cyc.size() < 1) begin
            failures++;
            $display("FAIL b2b_events: got %0d/%0d expected 2/1", acc0_cyc.size(), hs15_cyc.size());
        end else begin
            chk("b2b_first_accept_cycle", acc0_cyc[1], hs15_cyc[0] + 1);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
